// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an 8:1 one-bit mux: steps through enabled channels, settles, samples, builds a frame.
// Optional SCAN_PARITY_EN adds a frame_parity output (XOR of the completed frame).
module mux_scan_sequencer #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [7:0]    en_mask,
    input  logic [DW-1:0] dwell,
    input  logic          mux_out,
    output logic          s2,
    output logic          s1,
    output logic          s0,
    output logic          busy,
    output logic          sample_valid,
    output logic [2:0]    sample_ch,
    output logic          sample_bit,
    output logic [7:0]    frame,
    output logic          frame_valid
`ifdef SCAN_PARITY_EN
    ,
    output logic          frame_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE
    } state_t;

    state_t        state, state_d;
    logic [7:0]    mask_q, mask_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] cnt, cnt_d;
    logic [2:0]    sel, sel_d;
    logic          busy_d;
    logic          sample_valid_d;
    logic [2:0]    sample_ch_d;
    logic          sample_bit_d;
    logic [7:0]    frame_d;
    logic          frame_valid_d;
    logic [2:0]    first_ch;
    logic [2:0]    next_ch;
    logic          next_found;
`ifdef SCAN_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign s2 = sel[2];
    assign s1 = sel[1];
    assign s0 = sel[0];
`ifdef SCAN_PARITY_EN
    assign frame_parity = parity_q;
`endif

    // Lowest enabled channel of the incoming mask, used when a scan is accepted.
    always_comb begin
        first_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (en_mask[i]) first_ch = 3'(i);
        end
    end

    // Next enabled channel strictly above the current select, from the latched mask.
    always_comb begin
        next_ch    = 3'd0;
        next_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) > sel)) begin
                next_ch    = 3'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state;
        mask_d         = mask_q;
        dwell_d        = dwell_q;
        cnt_d          = cnt;
        sel_d          = sel;
        busy_d         = busy;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch;
        sample_bit_d   = sample_bit;
        frame_d        = frame;
        frame_valid_d  = 1'b0;
`ifdef SCAN_PARITY_EN
        parity_d       = parity_q;
`endif
        // stop outranks everything, including the final sample of a scan
        if (stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (en_mask != 8'd0)) begin
                        mask_d   = en_mask;
                        dwell_d  = dwell;
                        frame_d  = 8'd0;
                        sel_d    = first_ch;
                        cnt_d    = dwell;
                        busy_d   = 1'b1;
                        state_d  = SETTLE;
`ifdef SCAN_PARITY_EN
                        parity_d = 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt == '0) state_d = SAMPLE;
                    else           cnt_d   = cnt - DW'(1);
                end
                SAMPLE: begin
                    frame_d[sel]   = mux_out;
                    sample_bit_d   = mux_out;
                    sample_ch_d    = sel;
                    sample_valid_d = 1'b1;
                    if (next_found) begin
                        sel_d   = next_ch;
                        cnt_d   = dwell_q;
                        state_d = SETTLE;
                    end else begin
                        frame_valid_d = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = IDLE;
`ifdef SCAN_PARITY_EN
                        parity_d      = ^frame_d;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mask_q       <= 8'd0;
            dwell_q      <= '0;
            cnt          <= '0;
            sel          <= 3'd0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= 3'd0;
            sample_bit   <= 1'b0;
            frame        <= 8'd0;
            frame_valid  <= 1'b0;
`ifdef SCAN_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            mask_q       <= mask_d;
            dwell_q      <= dwell_d;
            cnt          <= cnt_d;
            sel          <= sel_d;
            busy         <= busy_d;
            sample_valid <= sample_valid_d;
            sample_ch    <= sample_ch_d;
            sample_bit   <= sample_bit_d;
            frame        <= frame_d;
            frame_valid  <= frame_valid_d;
`ifdef SCAN_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: vector table of scans, sample scoreboard, corner-case sequences.
// Build with SCAN_PARITY_EN defined to also check frame_parity.
module tb_mux_scan_sequencer;

    typedef struct {
        logic [7:0] mask;
        logic [3:0] dwell;
        logic [7:0] muxin;
        logic [7:0] exp_frame;
        int         exp_lat;
        bit         disturb;
    } vec_t;

    typedef struct {
        logic [2:0] ch;
        logic       b;
    } samp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] en_mask;
    logic [3:0] dwell;
    logic       mux_out;
    logic       s2, s1, s0;
    logic       busy;
    logic       sample_valid;
    logic [2:0] sample_ch;
    logic       sample_bit;
    logic [7:0] frame;
    logic       frame_valid;
`ifdef SCAN_PARITY_EN
    logic       frame_parity;
`endif

    logic [7:0] mux_in;
    int         checks = 0;
    int         errors = 0;
    int         sample_count = 0;
    int         frame_count = 0;
    samp_t      exp_q[$];
    samp_t      mon_s;
    vec_t       vecs[6];

    mux_scan_sequencer #(.DW(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .en_mask(en_mask),
        .dwell(dwell),
        .mux_out(mux_out),
        .s2(s2),
        .s1(s1),
        .s0(s0),
        .busy(busy),
        .sample_valid(sample_valid),
        .sample_ch(sample_ch),
        .sample_bit(sample_bit),
        .frame(frame),
        .frame_valid(frame_valid)
`ifdef SCAN_PARITY_EN
        ,
        .frame_parity(frame_parity)
`endif
    );

    // The mux being scanned
    assign mux_out = mux_in[{s2, s1, s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic sampleTick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pushExpected(input logic [7:0] mask, input logic [7:0] muxin, input int upto);
        for (int i = 0; i < upto; i++) begin
            if (mask[i]) exp_q.push_back('{ch: 3'(i), b: muxin[i]});
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_sel", {29'd0, s2, s1, s0}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
        checkOutput("rst_sample_ch", {29'd0, sample_ch}, 32'd0);
        checkOutput("rst_sample_bit", {31'd0, sample_bit}, 32'd0);
        checkOutput("rst_frame", {24'd0, frame}, 32'd0);
        checkOutput("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
`ifdef SCAN_PARITY_EN
        checkOutput("rst_frame_parity", {31'd0, frame_parity}, 32'd0);
`endif
    endtask

    // Scoreboard: every sample pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (sample_valid) begin
            sample_count++;
            checkOutput("sample_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                mon_s = exp_q.pop_front();
                checkOutput("sample_ch", {29'd0, sample_ch}, {29'd0, mon_s.ch});
                checkOutput("sample_bit", {31'd0, sample_bit}, {31'd0, mon_s.b});
            end
        end
        if (frame_valid) frame_count++;
    end

    task automatic applyStimulus(input vec_t v);
        int  cycles;
        bit  done;
        int  s0_cnt;
        int  f0_cnt;
        s0_cnt  = sample_count;
        f0_cnt  = frame_count;
        mux_in  = v.muxin;
        pushExpected(v.mask, v.muxin, 8);
        en_mask = v.mask;
        dwell   = v.dwell;
        pulseStart();
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 300) begin
            sampleTick();
            cycles++;
            if (v.disturb && cycles == 3) begin
                start   = 1'b1;
                en_mask = ~v.mask;
                dwell   = 4'd0;
            end else if (v.disturb && cycles == 4) begin
                start = 1'b0;
            end
            if (frame_valid) done = 1'b1;
        end
        checkOutput("frame_valid_seen", {31'd0, done}, 32'd1);
        checkOutput("scan_latency", cycles - 1, v.exp_lat);
        checkOutput("frame", {24'd0, frame}, {24'd0, v.exp_frame});
        checkOutput("busy_at_frame_valid", {31'd0, busy}, 32'd0);
`ifdef SCAN_PARITY_EN
        checkOutput("frame_parity", {31'd0, frame_parity}, {31'd0, ^v.exp_frame});
`endif
        sampleTick();
        checkOutput("frame_valid_width", {31'd0, frame_valid}, 32'd0);
        checkOutput("sample_pulses", sample_count - s0_cnt, $countones(v.mask));
        checkOutput("frame_pulses", frame_count - f0_cnt, 32'd1);
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        checkOutput("idle_after_frame", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s_base;
        int f_base;
        vecs[0] = '{mask: 8'hFF, dwell: 4'd0, muxin: 8'hA5, exp_frame: 8'hA5, exp_lat: 16, disturb: 1'b0};
        vecs[1] = '{mask: 8'h82, dwell: 4'd3, muxin: 8'hFF, exp_frame: 8'h82, exp_lat: 10, disturb: 1'b0};
        vecs[2] = '{mask: 8'h0F, dwell: 4'd1, muxin: 8'h3C, exp_frame: 8'h0C, exp_lat: 12, disturb: 1'b1};
        vecs[3] = '{mask: 8'h81, dwell: 4'd0, muxin: 8'h01, exp_frame: 8'h01, exp_lat: 4,  disturb: 1'b0};
        vecs[4] = '{mask: 8'h10, dwell: 4'd5, muxin: 8'hFF, exp_frame: 8'h10, exp_lat: 7,  disturb: 1'b0};
        vecs[5] = '{mask: 8'h5A, dwell: 4'd2, muxin: 8'hF0, exp_frame: 8'h50, exp_lat: 16, disturb: 1'b0};

        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        en_mask = 8'd0;
        dwell   = 4'd0;
        mux_in  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sampleTick();
        checkReset();

        $display("[TB] zero mask");
        s_base  = sample_count;
        f_base  = frame_count;
        en_mask = 8'h00;
        pulseStart();
        repeat (4) begin
            sampleTick();
            checkOutput("zero_mask_busy", {31'd0, busy}, 32'd0);
            checkOutput("zero_mask_sel", {29'd0, s2, s1, s0}, 32'd0);
        end
        checkOutput("zero_mask_pulses", (sample_count - s_base) + (frame_count - f_base), 32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        $display("[TB] abort during channel 3 sample");
        s_base  = sample_count;
        f_base  = frame_count;
        mux_in  = 8'hFF;
        en_mask = 8'hFF;
        dwell   = 4'd2;
        pushExpected(8'hFF, 8'hFF, 3);
        pulseStart();
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        sampleTick();
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_sample_valid", {31'd0, sample_valid}, 32'd0);
        checkOutput("abort_frame", {24'd0, frame}, 32'h07);
        checkOutput("abort_sel_held", {29'd0, s2, s1, s0}, 32'd3);
        repeat (3) sampleTick();
        checkOutput("abort_sample_pulses", sample_count - s_base, 32'd3);
        checkOutput("abort_frame_pulses", frame_count - f_base, 32'd0);
        checkOutput("abort_queue", exp_q.size(), 32'd0);

        $display("[TB] start and stop together in idle");
        en_mask = 8'hFF;
        stop    = 1'b1;
        pulseStart();
        stop = 1'b0;
        sampleTick();
        checkOutput("start_stop_busy", {31'd0, busy}, 32'd0);
        sampleTick();
        checkOutput("start_stop_busy_later", {31'd0, busy}, 32'd0);

        $display("[TB] reset during channel 5 settle");
        mux_in  = 8'hFF;
        en_mask = 8'hFF;
        dwell   = 4'd2;
        pushExpected(8'hFF, 8'hFF, 5);
        pulseStart();
        repeat (21) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_reset_sel", {29'd0, s2, s1, s0}, 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sampleTick();
        checkReset();
        checkOutput("reset_queue", exp_q.size(), 32'd0);
        applyStimulus('{mask: 8'h01, dwell: 4'd0, muxin: 8'h01, exp_frame: 8'h01, exp_lat: 2, disturb: 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the 8:1 one-bit mux stage.
- Drives the select lines s2/s1/s0 through the enabled channels in ascending order.
- Waits a programmable settle time on each channel, then samples the mux output.
- Assembles the sampled bits into an 8-bit frame with per-sample and per-frame valid pulses.

Parameters:
DW, 4, width of dwell (settle-count) input; settle time per channel = dwell+1 cycles

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to begin one scan; honoured only in IDLE
stop  input  1  abort current scan; honoured in any state
en_mask  input  8  channel enables, bit n = mux input n; latched on accepted start
dwell  input  DW  settle cycles minus one; latched on accepted start
mux_out  input  1  output of the 8:1 mux being scanned
s2  output  1  select MSB
s1  output  1  select mid bit
s0  output  1  select LSB
busy  output  1  high while not IDLE
sample_valid  output  1  one-cycle pulse, new sample_bit/sample_ch
sample_ch  output  3  channel of the current sample
sample_bit  output  1  sampled mux_out value
frame  output  8  assembled frame; bit n = channel n sample, disabled channels read 0
frame_valid  output  1  one-cycle pulse, frame complete

Behaviour:
- Reset: state IDLE. All outputs 0: {s2,s1,s0}=0, busy, sample_valid, sample_ch, sample_bit, frame, frame_valid. Internal mask, dwell and counter are cleared.
- Registered outputs: all outputs are registers; no combinational path from input to output.
- IDLE state:
  - start=1 and en_mask!=0: latch mask and dwell; clear frame to 0; drive sel = lowest set mask bit; load cnt=dwell; go to SETTLE. busy=1 from the next cycle.
  - start=1 and en_mask==0: ignored; stay IDLE, no pulses.
- SETTLE state: if cnt==0, go to SAMPLE; else cnt-=1. Occupies exactly dwell+1 cycles.
- SAMPLE state: one cycle. At the closing edge:
  - frame[sel] <= mux_out; sample_bit <= mux_out; sample_ch <= sel; sample_valid <= 1.
  - If a higher enabled channel exists: sel <= next higher set mask bit, cnt <= dwell, go to SETTLE.
  - Otherwise: frame_valid <= 1 (same cycle as the last sample_valid), go to IDLE. busy drops in that same cycle.
- Disabled channels: never selected and cost zero cycles.
- Scan length: N enabled channels take N*(dwell+2) cycles from the first SETTLE cycle to frame_valid.
- Select stability: {s2,s1,s0} changes only on the edge leaving SAMPLE or IDLE. It is held stable through the whole of SETTLE and SAMPLE.
- stop: has priority over all other events in the same cycle, including the final SAMPLE. Next state is IDLE; sample_valid and frame_valid are not pulsed on that edge; frame keeps its partial contents; sel holds its last value.
- Inputs while busy: start is ignored. en_mask and dwell changes have no effect on the scan in progress.
- start and stop together in IDLE: stop wins; remain IDLE.
- rst mid-scan: full reset values on the next edge; no pulses.
- Pulse width: sample_valid and frame_valid are exactly one cycle wide; both are 0 in every other cycle.

Optional Feature:
Macro SCAN_PARITY_EN.
- Defined: adds output frame_parity (1 bit) = XOR of all 8 frame bits. It updates on the same edge as frame_valid, holds until the next accepted start, is cleared to 0 on that start and on reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Full scan: rst, then en_mask=8'hFF, dwell=0, mux inputs 8'hA5, start pulse -> sel steps 0..7 every 2 cycles; 8 sample_valid pulses with sample_ch 0..7 and bits 1,0,1,0,0,1,0,1; frame=8'hA5 with frame_valid in cycle 16 after start; busy low the same cycle. With SCAN_PARITY_EN, frame_parity=0.
- Sparse mask and dwell: en_mask=8'h82, dwell=3, mux inputs 8'hFF -> only channels 1 and 7 selected, each held 5 cycles; frame=8'h82; frame_valid 10 cycles after first SETTLE.
- Zero mask: en_mask=0, start -> busy stays 0; no sample_valid or frame_valid; selects stay 0.
- Abort: en_mask=8'hFF, dwell=2, stop asserted during channel 3 SAMPLE -> no pulse on that edge; IDLE next cycle; frame bits 0..2 valid, bits 3..7 = 0; no frame_valid.
- Start while busy / input change: second start and en_mask change mid-scan -> ignored; original scan completes unchanged. Simultaneous start+stop in IDLE -> stays IDLE.
- Reset mid-scan: rst asserted during SETTLE of channel 5 -> all outputs 0 next cycle. A subsequent start with en_mask=8'h01 completes normally.
